// File: rtl/dma_intr_conditioner.sv
// dma_intr_conditioner: synchronise, edge-detect and rate-limit DMA interrupt lines into 1-cycle pulses with per-channel stats
module dma_intr_conditioner #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 4,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NCH-1:0]       intr_in,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       intr_pulse,
  output logic                 any_pulse,
  output logic [NCH-1:0]       sticky,
  output logic [NCH-1:0]       ovr,
  output logic [NCH*CNT_W-1:0] evt_cnt
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLD, WAIT_LOW} state_t;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise, drop, pulse_q, stk_q, ovr_q;
    logic [HOLDOFF_W-1:0]   hcnt;
    logic [CNT_W-1:0]       cnt;
    state_t                 state;
    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign drop = rise & (state == PULSE || state == HOLD);
    // bring the raw level into clk and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        sync <= '0;
        s_d  <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], intr_in[i]};
        s_d  <= s;
      end
    // accept an edge, emit one pulse, wait out the holdoff, then require the line to drop
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        state   <= IDLE;
        hcnt    <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= (state == IDLE) && rise;
        case (state)
          IDLE:     if (rise) state <= PULSE;
          PULSE: begin
            hcnt  <= holdoff;
            state <= (holdoff == '0) ? WAIT_LOW : HOLD;
          end
          HOLD: begin
            hcnt <= hcnt - 1'b1;
            if (hcnt == HOLDOFF_W'(1)) state <= WAIT_LOW;
          end
          default:  if (!s) state <= IDLE;
        endcase
      end
    // software-visible stats; a pulse or drop in the clearing cycle survives the clear
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
        cnt   <= '0;
        stk_q <= 1'b0;
        ovr_q <= 1'b0;
      end else if (clr[i]) begin
        cnt   <= CNT_W'(pulse_q);
        stk_q <= pulse_q;
        ovr_q <= drop;
      end else begin
        if (pulse_q && cnt != '1) cnt <= cnt + 1'b1;
        if (pulse_q) stk_q <= 1'b1;
        if (drop) ovr_q <= 1'b1;
      end
    assign intr_pulse[i]              = pulse_q;
    assign sticky[i]                  = stk_q;
    assign ovr[i]                     = ovr_q;
    assign evt_cnt[i*CNT_W +: CNT_W]  = cnt;
  end
  assign any_pulse = |intr_pulse;
endmodule

// File: tb/tb_dma_intr_conditioner.sv
// tb_dma_intr_conditioner: directed and random checks of the interrupt conditioner against a timestamp model
module tb_dma_intr_conditioner;
  localparam int SS = 2;
  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [7:0]   intr_in = '0;
  logic [7:0]   clr = '0;
  logic [3:0]   holdoff = '0;
  logic [7:0]   intr_pulse, sticky, ovr, p4, s4, o4;
  logic         any_pulse, a4;
  logic [127:0] evt16;
  logic [31:0]  evt4;
  int total = 0, bad = 0, cyc = 0, rst_cyc = 0;
  logic [7:0] hist [0:8191];
  int         busy_until [8];
  bit         need_low [8];
  int         cnt [8];
  logic [7:0] ep, es, eo;

  dma_intr_conditioner #(.NCH(8), .SYNC_STAGES(SS), .HOLDOFF_W(4), .CNT_W(16)) u16 (
    .clk(clk), .resetn(resetn), .intr_in(intr_in), .holdoff(holdoff), .clr(clr),
    .intr_pulse(intr_pulse), .any_pulse(any_pulse), .sticky(sticky), .ovr(ovr), .evt_cnt(evt16));
  dma_intr_conditioner #(.NCH(8), .SYNC_STAGES(SS), .HOLDOFF_W(4), .CNT_W(4)) u4 (
    .clk(clk), .resetn(resetn), .intr_in(intr_in), .holdoff(holdoff), .clr(clr),
    .intr_pulse(p4), .any_pulse(a4), .sticky(s4), .ovr(o4), .evt_cnt(evt4));

  always #5 clk = ~clk;

  function automatic logic [7:0] s_at(int t);
    return (t - SS < rst_cyc) ? 8'h00 : hist[t-SS];
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [127:0] e16;
    logic [31:0]  e4;
    e16 = '0;
    e4  = '0;
    for (int i = 0; i < 8; i++) begin
      e16[i*16 +: 16] = (cnt[i] > 65535) ? 16'hFFFF : 16'(cnt[i]);
      e4[i*4 +: 4]    = (cnt[i] > 15) ? 4'hF : 4'(cnt[i]);
    end
    chk("pulse", intr_pulse, ep);
    chk("any_pulse", any_pulse, |ep);
    chk("sticky", sticky, es);
    chk("ovr", ovr, eo);
    chk("evt_cnt16", evt16, e16);
    chk("evt_cnt4", evt4, e4);
    chk("pulse_w4", p4, ep);
  endtask

  task automatic model_reset();
    ep = '0; es = '0; eo = '0;
    for (int i = 0; i < 8; i++) begin
      busy_until[i] = -1;
      need_low[i]   = 1'b0;
      cnt[i]        = 0;
    end
  endtask

  // one clock: record this cycle's inputs, advance the model over it, compare the next cycle
  task automatic step();
    int t;
    logic [7:0] s_t, s_p, nxt;
    bit rise, drop;
    hist[cyc] = intr_in;
    @(posedge clk);
    #1;
    t = cyc;
    cyc++;
    s_t = s_at(t);
    s_p = s_at(t - 1);
    nxt = '0;
    for (int i = 0; i < 8; i++) begin
      rise = s_t[i] & ~s_p[i];
      if (ep[i]) begin
        busy_until[i] = t + int'(holdoff);
        need_low[i]   = 1'b1;
      end
      drop = rise && t <= busy_until[i];
      if (need_low[i] && t > busy_until[i] && !s_t[i]) need_low[i] = 1'b0;
      nxt[i] = rise && !need_low[i];
      if (clr[i]) begin
        cnt[i] = ep[i] ? 1 : 0;
        es[i]  = ep[i];
        eo[i]  = drop;
      end else begin
        cnt[i] += ep[i] ? 1 : 0;
        es[i]  |= ep[i];
        eo[i]  |= drop;
      end
    end
    ep = nxt;
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    check_all();
    resetn  = 1'b1;
    rst_cyc = cyc;
  endtask

  initial begin
    int last_p, min_gap, np;
    #2;
    do_reset();
    repeat (2) step();
    // single rising edge: pulse appears SS+1 edges after the change
    intr_in = 8'h01;
    repeat (SS) step();
    chk("t1_early", intr_pulse, 8'h00);
    step();
    chk("t1_pulse", intr_pulse, 8'h01);
    step();
    chk("t1_cnt", evt16[15:0], 16'd1);
    chk("t1_sticky", sticky[0], 1'b1);
    chk("t1_once", intr_pulse, 8'h00);
    repeat (4) step();
    // fast toggling under holdoff=4
    holdoff = 4'd4;
    last_p = -100; min_gap = 1000; np = 0;
    for (int k = 0; k < 10; k++) begin
      intr_in[3] = ~intr_in[3];
      repeat (2) begin
        step();
        if (intr_pulse[3]) begin
          if (cyc - last_p < min_gap) min_gap = cyc - last_p;
          last_p = cyc;
          np++;
        end
      end
    end
    chk("t2_gap_ok", min_gap >= 6, 1'b1);
    chk("t2_npulses_ok", np >= 2, 1'b1);
    chk("t2_ovr", ovr[3], 1'b1);
    intr_in = 8'h00;
    repeat (8) step();
    // all channels rise together after a full clear
    holdoff = 4'd0;
    clr = 8'hFF;
    step();
    clr = 8'h00;
    step();
    chk("t3_cleared", evt16, 128'd0);
    intr_in = 8'hFF;
    repeat (SS + 1) step();
    chk("t3_pulse", intr_pulse, 8'hFF);
    chk("t3_any", any_pulse, 1'b1);
    step();
    chk("t3_cnt", evt16, {8{16'd1}});
    intr_in = 8'h00;
    repeat (4) step();
    // 20 spaced edges on ch5 saturate the narrow counter
    for (int k = 0; k < 20; k++) begin
      intr_in[5] = 1'b1;
      repeat (3) step();
      intr_in[5] = 1'b0;
      repeat (3) step();
    end
    chk("t4_sat", evt4[23:20], 4'hF);
    chk("t4_wide", evt16[95:80], 16'd21);
    intr_in[5] = 1'b1;
    for (int k = 0; k < 6 && !ep[5]; k++) step();
    clr = 8'h20;
    step();
    clr = 8'h00;
    chk("t4_clr_cnt", evt4[23:20], 4'd1);
    chk("t4_clr_sticky", sticky[5], 1'b1);
    intr_in = 8'h00;
    repeat (6) step();
    // reset in the middle of a pulse with the line held high
    holdoff = 4'd3;
    intr_in = 8'h04;
    for (int k = 0; k < 6 && !ep[2]; k++) step();
    chk("t5_in_pulse", intr_pulse[2], 1'b1);
    do_reset();
    chk("t5_dropped", intr_pulse, 8'h00);
    np = 0;
    repeat (12) begin
      step();
      if (intr_pulse[2]) np++;
    end
    chk("t5_one_pulse", np, 1);
    // random traffic, clears and holdoff changes
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(3) == 0) intr_in[i] = ~intr_in[i];
      clr = ($urandom_range(15) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(31) == 0) holdoff = 4'($urandom_range(7));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
